// File: rtl/modbus_rtu_frame_ctrl.sv
// modbus_rtu_frame_ctrl
// MODBUS RTU framing between the UART byte stream and the protocol engine.
// RX: hunts for t3.5 silence, delimits frames by silence, checks CRC-16 and
//     flags inter-character (t1.5), overflow and short-frame errors.
// TX: waits for t3.5 silence, streams a PDU from the frame buffer, appends
//     CRC-16 (low byte first) and holds off until t3.5 post-silence.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_data/rx_valid         byte strobe from UART receiver
//   tx_data/tx_valid/tx_ready byte handshake to UART transmitter
//   rx_byte/rx_byte_valid    accepted frame bytes, rx_sof on the first
//   rx_eof/rx_crc_ok/rx_err  end-of-frame pulse with status
//   frm_tx_req/frm_tx_len    transmit request and PDU length (without CRC)
//   frm_rd_addr/frm_rd_data  frame buffer read port (1-cycle read latency)
//   frm_tx_done              transmit complete pulse
//   busy                     transmitter not idle
module modbus_rtu_frame_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int MAX_LEN   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_crc_ok,
  output logic       rx_err,
  input  logic       frm_tx_req,
  input  logic [8:0] frm_tx_len,
  output logic [7:0] frm_rd_addr,
  input  logic [7:0] frm_rd_data,
  output logic       frm_tx_done,
  output logic       busy
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int US_CLKS  = CLK_FREQ / 1_000_000;
  localparam int T15 = (BAUD_RATE <= 19200) ? BIT_CLKS * 33 / 2 : US_CLKS * 750;
  localparam int T35 = (BAUD_RATE <= 19200) ? BIT_CLKS * 77 / 2 : US_CLKS * 1750;
  localparam int CNT_W = $clog2(T35 + 1);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] T15_C = CNT_W'(T15);
  localparam logic [CNT_W-1:0] T35_C = CNT_W'(T35);
  localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {RX_HUNT, RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_FETCH, TX_SEND,
                            TX_CRC_LO, TX_CRC_HI, TX_GAP} tx_state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  rx_state_t        rx_state, rx_state_d;
  tx_state_t        tx_state, tx_state_d;
  logic [CNT_W-1:0] gap_cnt;
  logic [15:0]      rx_crc, rx_crc_d, tx_crc, tx_crc_d, tx_crc_upd;
  logic [LEN_W-1:0] rx_len, rx_len_d;
  logic             rx_ferr, rx_ferr_d;
  logic [7:0]       rx_byte_d, tx_data_d, frm_rd_addr_d;
  logic             rx_byte_valid_d, rx_sof_d, rx_eof_d, rx_crc_ok_d, rx_err_d;
  logic             tx_valid_d, frm_tx_done_d, fetch_ph, fetch_ph_d;
  logic [8:0]       tx_len, tx_len_d;
  logic             line_idle, tx_hs, rx_take;

  assign line_idle = (gap_cnt == T35_C);
  assign tx_hs     = tx_valid & tx_ready;
  assign busy      = (tx_state != TX_IDLE);
  assign rx_take   = rx_valid & ~busy;

  // Line silence counter, shared by RX delimiting and TX pacing.
  always_ff @(posedge clk) begin
    if (rst)                  gap_cnt <= '0;
    else if (rx_valid | tx_hs) gap_cnt <= '0;
    else if (!line_idle)      gap_cnt <= gap_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_HUNT;   tx_state <= TX_IDLE;
      rx_crc <= '1;          tx_crc <= '1;
      rx_len <= '0;          rx_ferr <= 1'b0;
      rx_byte <= '0;         rx_byte_valid <= 1'b0;
      rx_sof <= 1'b0;        rx_eof <= 1'b0;
      rx_crc_ok <= 1'b0;     rx_err <= 1'b0;
      tx_data <= '0;         tx_valid <= 1'b0;
      frm_rd_addr <= '0;     frm_tx_done <= 1'b0;
      tx_len <= '0;          fetch_ph <= 1'b0;
    end else begin
      rx_state <= rx_state_d; tx_state <= tx_state_d;
      rx_crc <= rx_crc_d;     tx_crc <= tx_crc_d;
      rx_len <= rx_len_d;     rx_ferr <= rx_ferr_d;
      rx_byte <= rx_byte_d;   rx_byte_valid <= rx_byte_valid_d;
      rx_sof <= rx_sof_d;     rx_eof <= rx_eof_d;
      rx_crc_ok <= rx_crc_ok_d; rx_err <= rx_err_d;
      tx_data <= tx_data_d;   tx_valid <= tx_valid_d;
      frm_rd_addr <= frm_rd_addr_d; frm_tx_done <= frm_tx_done_d;
      tx_len <= tx_len_d;     fetch_ph <= fetch_ph_d;
    end
  end

  always_comb begin
    rx_state_d      = rx_state;
    rx_crc_d        = rx_crc;
    rx_len_d        = rx_len;
    rx_ferr_d       = rx_ferr;
    rx_byte_d       = rx_byte;
    rx_byte_valid_d = 1'b0;
    rx_sof_d        = 1'b0;
    rx_eof_d        = 1'b0;
    rx_crc_ok_d     = 1'b0;
    rx_err_d        = 1'b0;
    unique case (rx_state)
      RX_HUNT: if (line_idle) rx_state_d = RX_IDLE;
      RX_IDLE: if (rx_take) begin
        rx_byte_d       = rx_data;
        rx_byte_valid_d = 1'b1;
        rx_sof_d        = 1'b1;
        rx_crc_d        = crc16_step(16'hFFFF, rx_data);
        rx_len_d        = LEN_W'(1);
        rx_ferr_d       = 1'b0;
        rx_state_d      = RX_RECV;
      end
      RX_RECV: begin
        // A byte landing on the same cycle the counter hits t3.5 wins over EOF.
        if (rx_valid) begin
          if (!busy) begin
            if (gap_cnt > T15_C) rx_ferr_d = 1'b1;
            if (rx_len < MAX_C) begin
              rx_byte_d       = rx_data;
              rx_byte_valid_d = 1'b1;
              rx_crc_d        = crc16_step(rx_crc, rx_data);
              rx_len_d        = rx_len + LEN_W'(1);
              if (rx_len_d == MAX_C) rx_ferr_d = 1'b1;
            end
          end
        end else if (line_idle) begin
          rx_eof_d    = 1'b1;
          rx_crc_ok_d = (rx_crc == 16'h0000) && (rx_len >= LEN_W'(4));
          rx_err_d    = rx_ferr || (rx_len < LEN_W'(4));
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_HUNT;
    endcase
  end

  always_comb begin
    tx_state_d     = tx_state;
    tx_crc_d       = tx_crc;
    tx_len_d       = tx_len;
    tx_data_d      = tx_data;
    tx_valid_d     = tx_valid;
    frm_rd_addr_d  = frm_rd_addr;
    fetch_ph_d     = fetch_ph;
    frm_tx_done_d  = 1'b0;
    tx_crc_upd     = crc16_step(tx_crc, tx_data);
    unique case (tx_state)
      TX_IDLE: if (frm_tx_req && frm_tx_len != '0 && frm_tx_len <= 9'(MAX_LEN - 2)) begin
        tx_len_d   = frm_tx_len;
        tx_crc_d   = 16'hFFFF;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (line_idle && rx_state != RX_RECV) begin
        frm_rd_addr_d = '0;
        fetch_ph_d    = 1'b0;
        tx_state_d    = TX_FETCH;
      end
      // First cycle presents the address to the buffer, second captures its data.
      TX_FETCH: if (!fetch_ph) begin
        fetch_ph_d = 1'b1;
      end else begin
        fetch_ph_d = 1'b0;
        tx_data_d  = frm_rd_data;
        tx_valid_d = 1'b1;
        tx_state_d = TX_SEND;
      end
      TX_SEND: if (tx_ready) begin
        tx_crc_d      = tx_crc_upd;
        frm_rd_addr_d = frm_rd_addr + 8'd1;
        if (({1'b0, frm_rd_addr} + 9'd1) < tx_len) begin
          tx_valid_d = 1'b0;
          tx_state_d = TX_FETCH;
        end else begin
          tx_data_d  = tx_crc_upd[7:0];
          tx_state_d = TX_CRC_LO;
        end
      end
      TX_CRC_LO: if (tx_ready) begin
        tx_data_d  = tx_crc[15:8];
        tx_state_d = TX_CRC_HI;
      end
      TX_CRC_HI: if (tx_ready) begin
        tx_valid_d = 1'b0;
        tx_state_d = TX_GAP;
      end
      TX_GAP: if (line_idle) begin
        frm_tx_done_d = 1'b1;
        tx_state_d    = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

endmodule

// File: doc/modbus_rtu_frame_ctrl.md
# modbus_rtu_frame_ctrl

Sequences MODBUS RTU framing on top of the byte-level UART interface. On receive, it delimits frames by line silence (t1.5/t3.5), strips nothing, checks CRC-16 and flags errors. On transmit, it enforces t3.5 pre-silence, streams a stored PDU from the frame buffer RAM, appends CRC-16 and enforces post-silence. It sits between the UART byte stream and the MODBUS protocol engine and frame buffer.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD_RATE, 9600, line rate; character = 11 bits
- MAX_LEN, 256, maximum frame length in bytes including CRC
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  UART can accept byte
- rx_byte  out  8  received frame byte
- rx_byte_valid  out  1  one-cycle strobe per accepted frame byte
- rx_sof  out  1  coincides with first byte's rx_byte_valid
- rx_eof  out  1  one-cycle pulse at t3.5 after last byte
- rx_crc_ok  out  1  valid with rx_eof: CRC residue 0 and length ≥ 4
- rx_err  out  1  valid with rx_eof: t1.5 violation, overflow or length < 4
- frm_tx_req  in  1  start transmit, sampled only in TX_IDLE
- frm_tx_len  in  9  PDU bytes excluding CRC, 1..MAX_LEN-2
- frm_rd_addr  out  8  frame buffer read address
- frm_rd_data  in  8  buffer data, valid one cycle after address
- frm_tx_done  out  1  one-cycle pulse when transmit complete
- busy  out  1  high whenever TX state ≠ TX_IDLE

## Operation
- Timing constants:
  - BAUD_RATE ≤ 19200: T15 = (CLK_FREQ/BAUD_RATE)*33/2 clocks and T35 = (CLK_FREQ/BAUD_RATE)*77/2 clocks.
  - BAUD_RATE > 19200: fixed 750 µs and 1750 µs, i.e. CLK_FREQ/1_000_000 × 750 and × 1750.
- Gap counter:
  - Clears on rx_valid and on each tx handshake (tx_valid & tx_ready).
  - Otherwise increments, saturating at T35.
  - Reset value 0, so the line is not idle until T35 clocks have elapsed after reset.
- CRC-16/MODBUS: reflected polynomial 0xA001, init 0xFFFF, one byte per cycle (8 unrolled shift steps, combinational).
- RX FSM:
  - RX_HUNT:
    - Bytes arriving are discarded.
    - Move to RX_IDLE when the counter reaches T35.
  - RX_IDLE:
    - On rx_valid: emit the byte with rx_sof, init CRC and update it, len = 1, go to RX_RECV.
  - RX_RECV:
    - On rx_valid: emit the byte and update CRC and len.
    - A byte arriving with counter > T15 sets the frame err flag. The byte is still emitted.
    - len reaching MAX_LEN sets err. Further bytes are not emitted until EOF.
    - When the counter reaches T35: pulse rx_eof with rx_crc_ok and rx_err, then go to RX_IDLE.
  - Receive is ignored while busy (echo suppression). rx_valid still clears the counter.
- TX FSM:
  - TX_IDLE:
    - On frm_tx_req: latch len, init CRC, go to TX_WAIT.
  - TX_WAIT:
    - Wait for counter == T35 and RX not in RX_RECV.
    - Then drive frm_rd_addr = 0 and go to TX_FETCH.
  - TX_FETCH:
    - Capture frm_rd_data the next cycle into tx_data, raise tx_valid, go to TX_SEND.
  - TX_SEND:
    - On handshake: update CRC, increment address.
    - If bytes remain, go to TX_FETCH; otherwise go to TX_CRC_LO.
  - TX_CRC_LO: send crc[7:0].
  - TX_CRC_HI: send crc[15:8].
  - TX_GAP:
    - Wait for counter == T35, pulse frm_tx_done, go to TX_IDLE.
- frm_tx_len values of 0 or greater than MAX_LEN-2: request ignored, stays in TX_IDLE.

## Timing
- Reset values: all outputs 0, RX = RX_HUNT, TX = TX_IDLE, CRC = 0xFFFF.
- rx_byte_valid is registered: 1 cycle after rx_valid.
- rx_eof is 1 cycle after the counter hits T35.
- tx_valid must not drop and tx_data must not change until tx_ready is seen high with tx_valid. At most one byte is accepted per handshake.
- frm_tx_req during TX_GAP is ignored. The requester waits for frm_tx_done.
- Simultaneous rx_valid and the counter reaching T35 in RX_RECV: the byte belongs to the current frame and the counter clears; no EOF.
- rst mid-frame: RX/TX abort immediately, with no frm_tx_done or rx_eof. The hunt restarts.

## Test plan
- After reset, rx_valid at cycle 10 → no rx_byte_valid (hunt). Idle T35, then bytes 01 03 00 00 00 01 84 0A spaced 1 char apart → 8 rx_byte_valid strobes, rx_sof on the first, rx_eof at T35 after the last with rx_crc_ok=1, rx_err=0.
- Same frame with the last byte altered to 0B → rx_eof with rx_crc_ok=0.
- Gap of T15+100 clocks between bytes 3 and 4 → all bytes emitted, rx_eof with rx_err=1.
- Buffer holds 01 03 00 00 00 01, frm_tx_req with len=6 → first tx_valid no earlier than T35 after the last line activity. Bytes 01 03 00 00 00 01 84 0A go out; frm_tx_done fires T35 after the last handshake.
- TX with tx_ready held low 50 cycles per byte → tx_data stable, no byte lost or duplicated, busy high throughout.
- rst asserted during TX_SEND byte 3 → tx_valid=0 next cycle, busy=0, no frm_tx_done. The next request succeeds after a fresh T35.
